// File: rtl/xbar_rr_scheduler.sv
// xbar_rr_scheduler: round-robin owner selection for the shared crossbar datapath.
// Each owner keeps the grant for at most QUANTUM acked transactions, and one idle
// cycle always separates two owners.
// Optional feature: define XBAR_SCHED_TIMEOUT_EN to force a release after TIMEOUT
// grant cycles without an ack.
module xbar_rr_scheduler #(
    parameter int unsigned N       = 4,
    parameter int unsigned QUANTUM = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [N-1:0]         req_i,
    input  logic                 ack_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_id_o,
    output logic                 timeout_o
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned QW = $clog2(QUANTUM + 1);

    // Reject configurations the scheduler cannot honour.
    if (N < 2) begin : g_bad_n
        $error("xbar_rr_scheduler: N must be at least 2");
    end
    if (QUANTUM < 1) begin : g_bad_quantum
        $error("xbar_rr_scheduler: QUANTUM must be at least 1");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("xbar_rr_scheduler: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [QW-1:0]   qcnt_q,  qcnt_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_d;
    logic            to_fire;
    logic            release_c;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   win_idx;
    logic            win_hit;

`ifdef XBAR_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT);
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout_q;
`endif

    // Round-robin pick: first requester after last, with last itself scanned last.
    always_comb begin
        win_idx = '0;
        win_hit = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(last_q) + 32'd1 + i) % N);
            if (!win_hit && req_i[cand]) begin
                win_idx = cand;
                win_hit = 1'b1;
            end
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        qcnt_d    = qcnt_q;
        timeout_d = 1'b0;
        to_fire   = 1'b0;
        release_c = 1'b0;
`ifdef XBAR_SCHED_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        case (state_q)
            IDLE, GAP: begin
                if (win_hit) begin
                    owner_d = win_idx;
                    last_d  = win_idx;
                    qcnt_d  = '0;
`ifdef XBAR_SCHED_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (ack_i) begin
                    qcnt_d = qcnt_q + QW'(1);
                end
`ifdef XBAR_SCHED_TIMEOUT_EN
                tcnt_d  = ack_i ? '0 : tcnt_q + TW'(1);
                to_fire = !ack_i && (tcnt_q == TW'(TIMEOUT - 1));
`endif
                release_c = !req_i[owner_q]
                          || (ack_i && (qcnt_q == QW'(QUANTUM - 1)))
                          || to_fire;
                if (release_c) begin
                    state_d   = GAP;
                    timeout_d = to_fire;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? (N'(1) << owner_d) : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= IW'(N - 1);
            qcnt_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
`ifdef XBAR_SCHED_TIMEOUT_EN
            tcnt_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            qcnt_q      <= qcnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef XBAR_SCHED_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_id_o    = owner_q;

`ifdef XBAR_SCHED_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Bench for xbar_rr_scheduler: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the round-robin rules.
module tb_xbar_rr_scheduler;

    localparam int N       = 4;
    localparam int QUANTUM = 4;
    localparam int TIMEOUT = 16;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic [N-1:0] req_i;
    logic         ack_i;
    logic [N-1:0] gnt_o;
    logic         gnt_valid_o;
    logic [1:0]   gnt_id_o;
    logic         timeout_o;

    xbar_rr_scheduler #(
        .N       (N),
        .QUANTUM (QUANTUM),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_id_o    (gnt_id_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] req;
        logic         ack;
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         tout;
    } vec_t;

    vec_t tab[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model: owner is -1 when nobody holds the bus.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_id    = 0;
    int m_acks  = 0;
    int m_quiet = 0;
    bit m_tout  = 1'b0;

    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst_n, input logic [N-1:0] req, input logic ack);
        int w;
        bit fire;
        if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_id = 0;
            m_acks = 0; m_quiet = 0; m_tout = 1'b0;
            return;
        end
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            if (ack) begin
                m_acks++;
                m_quiet = 0;
            end else begin
                m_quiet++;
            end
`ifdef XBAR_SCHED_TIMEOUT_EN
            fire = !ack && (m_quiet == TIMEOUT);
`else
            fire = 1'b0;
`endif
            if (!req[m_owner] || m_acks == QUANTUM || fire) begin
                m_owner = -1;
                m_tout  = fire;
            end
        end else begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_id = w;
                m_acks = 0; m_quiet = 0;
            end
        end
    endtask

    task automatic compare(input string name, input logic [N-1:0] eg, input logic [1:0] eid,
                           input logic et);
        vectors++;
        if (gnt_o !== eg || gnt_valid_o !== (|eg) || gnt_id_o !== eid || timeout_o !== et) begin
            miscompares++;
            $display("FAIL %s @%0t: got gnt=%b valid=%b id=%0d tout=%b, want gnt=%b valid=%b id=%0d tout=%b",
                     name, $time, gnt_o, gnt_valid_o, gnt_id_o, timeout_o, eg, |eg, eid, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        compare(name, eg, 2'(m_id), m_tout);
    endtask

    // One clock: drive inputs, advance the model, sample just after the edge.
    task automatic cyc(input logic rst_n, input logic [N-1:0] req, input logic ack);
        reset_ni = rst_n; req_i = req; ack_i = ack;
        @(posedge clk_i);
        model_step(rst_n, req, ack);
        #1;
    endtask

    task automatic step_chk(input string name, input logic rst_n, input logic [N-1:0] req,
                            input logic ack);
        cyc(rst_n, req, ack);
        check_model(name);
    endtask

    task automatic expect_gnt(input string name, input logic [N-1:0] eg, input logic et);
        vectors++;
        if (gnt_o !== eg || timeout_o !== et) begin
            miscompares++;
            $display("FAIL %s @%0t: got gnt=%b tout=%b, want gnt=%b tout=%b",
                     name, $time, gnt_o, timeout_o, eg, et);
        end
    endtask

    task automatic add(input logic r, input logic [N-1:0] q, input logic a,
                       input logic [N-1:0] g, input int id);
        vec_t v;
        v.rst_n = r; v.req = q; v.ack = a; v.gnt = g; v.id = 2'(id); v.tout = 1'b0;
        tab.push_back(v);
    endtask

    initial begin
        logic [N-1:0] rq;
        logic         ak;
        logic         rs;
        reset_ni = 1'b0; req_i = '0; ack_i = 1'b0;

        // Reset with all hosts requesting, then quantum rotation 0,1,2,3,0.
        for (int i = 0; i < 3; i++) add(1'b0, 4'b1111, 1'b0, 4'b0000, 0);
        add(1'b1, 4'b1111, 1'b0, 4'b0001, 0);
        for (int h = 0; h < N; h++) begin
            for (int a = 1; a < QUANTUM; a++) add(1'b1, 4'b1111, 1'b1, N'(1 << h), h);
            add(1'b1, 4'b1111, 1'b1, 4'b0000, h);
            add(1'b1, 4'b1111, (h == 1) ? 1'b0 : 1'b1, N'(1 << ((h + 1) % N)), (h + 1) % N);
        end
        foreach (tab[i]) begin
            cyc(tab[i].rst_n, tab[i].req, tab[i].ack);
            compare($sformatf("table[%0d]", i), tab[i].gnt, tab[i].id, tab[i].tout);
        end

        // Early drop: host 2 drops after one ack, host 3 follows.
        cyc(1'b0, 4'b0000, 1'b0);
        step_chk("drop_grant", 1'b1, 4'b0100, 1'b0);
        expect_gnt("drop_grant2", 4'b0100, 1'b0);
        step_chk("drop_ack", 1'b1, 4'b0100, 1'b1);
        step_chk("drop_gap", 1'b1, 4'b1010, 1'b0);
        expect_gnt("drop_gap0", 4'b0000, 1'b0);
        step_chk("drop_next", 1'b1, 4'b1010, 1'b0);
        expect_gnt("drop_next3", 4'b1000, 1'b0);

        // Sole requester re-wins after its quantum and one gap cycle.
        cyc(1'b0, 4'b0000, 1'b0);
        step_chk("sole_grant", 1'b1, 4'b0100, 1'b1);
        for (int a = 1; a <= QUANTUM; a++) begin
            cyc(1'b1, 4'b0100, 1'b1);
            expect_gnt($sformatf("sole_ack%0d", a), (a == QUANTUM) ? 4'b0000 : 4'b0100, 1'b0);
        end
        cyc(1'b1, 4'b0100, 1'b1);
        expect_gnt("sole_rewin", 4'b0100, 1'b0);

        // Mid-grant reset drops the grant at once; host 3 wins afterwards.
        cyc(1'b0, 4'b0000, 1'b0);
        step_chk("mid_grant", 1'b1, 4'b1000, 1'b0);
        step_chk("mid_ack", 1'b1, 4'b1000, 1'b1);
        step_chk("mid_reset", 1'b0, 4'b1000, 1'b1);
        expect_gnt("mid_reset0", 4'b0000, 1'b0);
        step_chk("mid_regrant", 1'b1, 4'b1000, 1'b0);
        expect_gnt("mid_regrant3", 4'b1000, 1'b0);

        // Ack-less grant: forced release when the timeout is built in, held otherwise.
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0);
        expect_gnt("to_grant", 4'b0010, 1'b0);
`ifdef XBAR_SCHED_TIMEOUT_EN
        for (int c = 1; c <= TIMEOUT; c++) begin
            cyc(1'b1, 4'b0011, 1'b0);
            expect_gnt($sformatf("to_cycle%0d", c), (c == TIMEOUT) ? 4'b0000 : 4'b0010,
                       c == TIMEOUT);
        end
        cyc(1'b1, 4'b0011, 1'b0);
        expect_gnt("to_next", 4'b0001, 1'b0);
`else
        for (int c = 1; c <= 2 * TIMEOUT; c++) cyc(1'b1, 4'b0011, 1'b0);
        expect_gnt("to_held", 4'b0010, 1'b0);
`endif

        // Randomized traffic against the model.
        cyc(1'b0, 4'b0000, 1'b0);
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, N - 1)] = ~rq[$urandom_range(0, N - 1)];
            if ($urandom_range(0, 15) == 0) rq = 4'($urandom);
            ak = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 60 : 4));
            rs = ($urandom_range(0, 199) != 0);
            step_chk("random", rs, rq, ak);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
